quad_encoder_gen: RTL and testbench

Quadrature encoder emulator. Converts step requests (valid/ready, direction) into A/B quadrature waveforms on two output pins, with optional LFSR-driven contact bounce on each edge. Used for on-board self-test and loopback of the rotary-encoder input path. It drives the pins that the encoder input filter and decoder consume, and keeps a signed count of emitted steps.

---
 rtl/quad_encoder_gen_pkg.sv | 24 ++
 rtl/quad_encoder_gen_lfsr16.sv | 22 ++
 rtl/quad_encoder_gen.sv | 130 +++++++++++++
 tb/tb_quad_encoder_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/quad_encoder_gen_pkg.sv
// Shared constants for the quadrature encoder emulator: FSM state codes,
// per-quarter AB targets for each direction, and the LFSR seed/taps.
// Pure declarations; no logic, no latency, no flow control.
package quad_pkg;

  // FSM state codes
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BOUNCE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // AB targets ({A,B}) indexed by quarter index; both tables return to rest 00
  localparam logic [1:0] CW_AB  [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  localparam logic [1:0] CCW_AB [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  // Galois LFSR for x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // AB target for a given direction (1 = CW) and quarter index
  function automatic logic [1:0] quarter_ab(input logic dir, input logic [1:0] idx);
    return dir ? CW_AB[idx] : CCW_AB[idx];
  endfunction

endpackage

// File: rtl/quad_encoder_gen_lfsr16.sv
// 16-bit Galois LFSR used as the contact-bounce noise source.
// Latency: one step per enabled clock; q is the registered state.
// No backpressure: advances whenever en is high.
module lfsr16
  import quad_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  // Shift right, folding the taps in when the outgoing bit is 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: turns accepted step requests into A/B waveforms.
// Latency: pins move on the accept edge; a step lasts 4*(BOUNCE_CYCLES*BOUNCE_EN+PHASE_CYCLES).
// Backpressure: step_ready low for the whole step; requests while busy are dropped.
module quad_encoder_gen
  import quad_pkg::*;
#(
  parameter int PHASE_CYCLES  = 2048,
  parameter int BOUNCE_CYCLES = 64,
  parameter int BOUNCE_EN     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_valid,
  input  logic               step_dir,
  output logic               step_ready,
  output logic               enc_a,
  output logic               enc_b,
  output logic               busy,
  output logic signed [15:0] pos
);

  localparam int MAX_CYC = (PHASE_CYCLES > BOUNCE_CYCLES) ? PHASE_CYCLES : BOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] PH_LOAD = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BN_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic             USE_BOUNCE = (BOUNCE_EN != 0);

  logic [1:0]        state;
  logic [1:0]        idx;
  logic              dir_q;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        ab_q;
  logic signed [15:0] pos_q;
  logic [15:0]       lfsr_q;
  logic              lfsr_en;
  logic              lfsr_unused;

  logic [1:0] tgt_cur;
  logic [1:0] tgt_nxt;
  logic [1:0] tgt_first;
  logic [1:0] chg_mask;
  logic [1:0] bounce_ab;

  assign lfsr_en = (state == ST_BOUNCE);

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (lfsr_en),
    .q   (lfsr_q)
  );

  // Only bit 0 feeds the bounce; upper bits are the generator's internal state
  assign lfsr_unused = &{1'b0, lfsr_q[15:1]};

  // Targets for the current, next and first quarter. The previous target for
  // quarter 0 is rest (00); idx-1 wraps to 3 whose entry is also 00.
  always_comb begin
    tgt_cur   = quarter_ab(dir_q, idx);
    tgt_nxt   = quarter_ab(dir_q, idx + 2'd1);
    tgt_first = quarter_ab(step_dir, 2'd0);
    chg_mask  = tgt_cur ^ quarter_ab(dir_q, idx - 2'd1);
    bounce_ab = (tgt_cur & ~chg_mask) | (chg_mask & {2{lfsr_q[0]}});
  end

  // Step sequencer: accept, per-quarter bounce/hold timing, position update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= 2'd0;
      dir_q <= 1'b0;
      cnt   <= '0;
      ab_q  <= 2'b00;
      pos_q <= 16'sd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (step_valid) begin
            dir_q <= step_dir;
            idx   <= 2'd0;
            ab_q  <= tgt_first;
            if (USE_BOUNCE) begin
              state <= ST_BOUNCE;
              cnt   <= BN_LOAD;
            end else begin
              state <= ST_HOLD;
              cnt   <= PH_LOAD;
            end
          end
        end
        ST_BOUNCE: begin
          if (cnt == '0) begin
            state <= ST_HOLD;
            cnt   <= PH_LOAD;
            ab_q  <= tgt_cur;
          end else begin
            cnt   <= cnt - 1'b1;
            ab_q  <= bounce_ab;
          end
        end
        ST_HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (idx != 2'd3) begin
            idx  <= idx + 2'd1;
            ab_q <= tgt_nxt;
            if (USE_BOUNCE) begin
              state <= ST_BOUNCE;
              cnt   <= BN_LOAD;
            end else begin
              state <= ST_HOLD;
              cnt   <= PH_LOAD;
            end
          end else begin
            state <= ST_IDLE;
            pos_q <= dir_q ? (pos_q + 16'sd1) : (pos_q - 16'sd1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign step_ready = (state == ST_IDLE);
  assign busy       = ~step_ready;
  assign enc_a      = ab_q[1];
  assign enc_b      = ab_q[0];
  assign pos        = pos_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: one instance without bounce and
// one with bounce, both PHASE_CYCLES=8, BOUNCE_CYCLES=4.
module tb_quad_encoder_gen;

  localparam int P = 8;
  localparam int B = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic v0, d0, r0, a0, b0, bz0;
  logic v1, d1, r1, a1, b1, bz1;
  logic signed [15:0] p0, p1;

  quad_encoder_gen #(.PHASE_CYCLES(P), .BOUNCE_CYCLES(B), .BOUNCE_EN(0)) dut0 (
    .clk(clk), .rst(rst), .step_valid(v0), .step_dir(d0), .step_ready(r0),
    .enc_a(a0), .enc_b(b0), .busy(bz0), .pos(p0)
  );

  quad_encoder_gen #(.PHASE_CYCLES(P), .BOUNCE_CYCLES(B), .BOUNCE_EN(1)) dut1 (
    .clk(clk), .rst(rst), .step_valid(v1), .step_dir(d1), .step_ready(r1),
    .enc_a(a1), .enc_b(b1), .busy(bz1), .pos(p1)
  );

  int checks = 0;
  int errors = 0;
  logic sel = 1'b0;
  logic signed [15:0] exp_pos0, exp_pos1;
  logic [15:0] lfsr_m;

  logic [1:0] ob_ab;
  logic ob_rdy, ob_busy;
  logic signed [15:0] ob_pos;
  assign ob_ab   = sel ? {a1, b1} : {a0, b0};
  assign ob_rdy  = sel ? r1 : r0;
  assign ob_busy = sel ? bz1 : bz0;
  assign ob_pos  = sel ? p1 : p0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Settled AB after k transitions: CW puts Gray(k) on {B,A}, CCW on {A,B}
  function automatic logic [1:0] model_ab(input logic dir, input int k);
    int m;
    logic [1:0] g;
    m = k % 4;
    g = 2'(m ^ (m >> 1));
    return dir ? {g[0], g[1]} : g;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  task automatic drive(input logic s, input logic v, input logic d);
    if (s) begin v1 = v; d1 = d; end
    else begin v0 = v; d0 = d; end
  endtask

  task automatic wait_ready(input int lim);
    int n;
    n = 0;
    while (!ob_rdy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 32'(ob_rdy), 32'd1);
  endtask

  // One fully checked step on the selected instance, cycle by cycle
  task automatic run_step(input logic s, input logic dir);
    logic [1:0] prev, tgt, mask;
    logic exp_bit;
    int nb;
    sel = s;
    nb = s ? B : 0;
    wait_ready(200);
    drive(s, 1'b1, dir);
    @(posedge clk);
    @(negedge clk);
    drive(s, 1'b0, 1'b0);
    prev = 2'b00;
    exp_bit = 1'b0;
    for (int q = 0; q < 4; q++) begin
      tgt  = model_ab(dir, q + 1);
      mask = tgt ^ prev;
      for (int c = 0; c < nb; c++) begin
        chk("bnc_ready", 32'(ob_rdy), 32'd0);
        chk("bnc_stable", 32'(ob_ab & ~mask), 32'(tgt & ~mask));
        if (c == 0) chk("bnc_first", 32'(ob_ab & mask), 32'(tgt & mask));
        else        chk("bnc_noise", 32'(ob_ab & mask), 32'({2{exp_bit}} & mask));
        exp_bit = lfsr_m[0];
        lfsr_m  = lfsr_next(lfsr_m);
        @(negedge clk);
      end
      for (int c = 0; c < P; c++) begin
        chk("hold_ab", 32'(ob_ab), 32'(tgt));
        chk("hold_busy", 32'(ob_busy), 32'd1);
        @(negedge clk);
      end
      prev = tgt;
    end
    if (s) exp_pos1 = dir ? exp_pos1 + 16'sd1 : exp_pos1 - 16'sd1;
    else   exp_pos0 = dir ? exp_pos0 + 16'sd1 : exp_pos0 - 16'sd1;
    chk("end_ready", 32'(ob_rdy), 32'd1);
    chk("end_ab", 32'(ob_ab), 32'd0);
    chk("end_pos", 32'(ob_pos), 32'(s ? exp_pos1 : exp_pos0));
  endtask

  int t_acc [4];
  int n_acc;
  logic bdir;

  initial begin
    rst = 1'b1;
    v0 = 1'b0; d0 = 1'b0; v1 = 1'b0; d1 = 1'b0;
    exp_pos0 = 16'sd0; exp_pos1 = 16'sd0;
    lfsr_m = 16'hACE1;
    repeat (3) @(negedge clk);
    chk("rst_ab0", 32'({a0, b0}), 32'd0);
    chk("rst_ab1", 32'({a1, b1}), 32'd0);
    chk("rst_rdy0", 32'(r0), 32'd1);
    chk("rst_busy1", 32'(bz1), 32'd0);
    chk("rst_pos0", 32'(p0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed single steps in each mode
    run_step(1'b0, 1'b1);
    run_step(1'b1, 1'b0);

    // Reset in the middle of quarter 2 hold on the bouncing instance
    sel = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0);
    repeat (29) @(negedge clk);
    chk("mid_busy", 32'(bz1), 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_ab", 32'({a1, b1}), 32'd0);
    chk("mrst_rdy", 32'(r1), 32'd1);
    chk("mrst_pos1", 32'(p1), 32'd0);
    chk("mrst_pos0", 32'(p0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_pos0 = 16'sd0; exp_pos1 = 16'sd0;
    lfsr_m = 16'hACE1;
    @(negedge clk);
    run_step(1'b1, 1'b1);

    // Random directions on both instances
    for (int i = 0; i < 6; i++) begin
      bdir = 1'($urandom_range(0, 1));
      run_step(logic'(i % 2), bdir);
    end

    // Requests while busy are dropped
    sel = 1'b0;
    bdir = 1'($urandom_range(0, 1));
    drive(1'b0, 1'b1, bdir);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    drive(1'b0, 1'b1, ~bdir);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    wait_ready(100);
    exp_pos0 = bdir ? exp_pos0 + 16'sd1 : exp_pos0 - 16'sd1;
    chk("ign_pos", 32'(p0), 32'(exp_pos0));
    repeat (3) @(negedge clk);
    chk("ign_noqueue", 32'(r0), 32'd1);

    // Back-to-back with step_valid held high
    n_acc = 0;
    drive(1'b0, 1'b1, 1'b1);
    for (int cyc = 0; cyc < 110; cyc++) begin
      if (v0 && r0 && n_acc < 4) begin
        t_acc[n_acc] = cyc;
        n_acc++;
      end
      @(negedge clk);
      if (n_acc == 3) drive(1'b0, 1'b0, 1'b0);
    end
    exp_pos0 = exp_pos0 + 16'sd3;
    chk("b2b_accepts", 32'(n_acc), 32'd3);
    if (n_acc >= 3) begin
      chk("b2b_gap1", 32'(t_acc[1] - t_acc[0]), 32'd33);
      chk("b2b_gap2", 32'(t_acc[2] - t_acc[1]), 32'd33);
    end
    chk("b2b_pos", 32'(p0), 32'(exp_pos0));

    // Position wrap at the 16-bit boundaries
    force dut0.pos_q = 16'sh7fff;
    @(negedge clk);
    release dut0.pos_q;
    exp_pos0 = 16'sh7fff;
    run_step(1'b0, 1'b1);
    chk("wrap_up", 32'(p0), 32'hffff8000);
    run_step(1'b0, 1'b0);
    chk("wrap_down", 32'(p0), 32'h00007fff);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
